// File: rtl/openram_sram_model.sv
// Behavioural single-port SRAM standing in for an OpenRAM hard macro.
// Samples csb/web/addr/din on each rising edge; read data appears on dout
// with a one-cycle dValid pulse ReadLatency cycles after the request cycle.
// Out-of-range accesses set the sticky oobErr flag; out-of-range reads
// complete with zero data.
// Optional feature: define OPENRAM_WMASK_EN to add a per-byte write mask.
module openram_sram_model #(
    parameter int DataWidth   = 32,
    parameter int AddrWidth   = 32,
    parameter int Depth       = 1024,
    parameter int ReadLatency = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   csb,
    input  logic                   web,
    input  logic [AddrWidth-1:0]   addr,
    input  logic [DataWidth-1:0]   din,
`ifdef OPENRAM_WMASK_EN
    input  logic [DataWidth/8-1:0] wmask,
`endif
    output logic [DataWidth-1:0]   dout,
    output logic                   dValid,
    output logic                   oobErr
);

    localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [AddrWidth:0] DepthLim = (AddrWidth + 1)'(Depth);

    if (ReadLatency < 1 || ReadLatency > 4) begin : g_bad_latency
        $error("openram_sram_model: ReadLatency must be in 1..4");
    end
    if (DataWidth % 8 != 0) begin : g_bad_width
        $error("openram_sram_model: DataWidth must be a multiple of 8");
    end
    if (AddrWidth < 31 && Depth > (1 << AddrWidth)) begin : g_bad_depth
        $error("openram_sram_model: Depth exceeds the address space");
    end

    logic [DataWidth-1:0] mem [Depth];

    logic                 in_range;
    logic                 access;
    logic                 do_write;
    logic                 do_read;
    logic [IdxW-1:0]      idx;
    logic [DataWidth-1:0] rd_data;

    // Final pipeline stage feeding the output register.
    logic                 tail_v;
    logic [DataWidth-1:0] tail_d;

    // Decode the sampled request; requests made while reset is high are ignored.
    always_comb begin
        idx      = addr[IdxW-1:0];
        in_range = {1'b0, addr} < DepthLim;
        access   = !reset && !csb;
        do_write = access && !web && in_range;
        do_read  = access && web;
        rd_data  = in_range ? mem[idx] : '0;
    end

    // Array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
`ifdef OPENRAM_WMASK_EN
            for (int unsigned b = 0; b < unsigned'(DataWidth / 8); b++) begin
                if (wmask[b]) begin
                    mem[idx][8*b +: 8] <= din[8*b +: 8];
                end
            end
`else
            mem[idx] <= din;
`endif
        end
    end

    // With ReadLatency=1 the output register itself is stage 1, so the
    // sampled word goes straight to dout; otherwise ReadLatency-1 stages
    // sit in front of it.
    if (ReadLatency == 1) begin : g_direct
        assign tail_v = do_read;
        assign tail_d = rd_data;
    end else begin : g_pipe
        logic                 stage_v [ReadLatency-1];
        logic [DataWidth-1:0] stage_d [ReadLatency-1];

        // Valid bits: cleared by reset so in-flight reads are dropped.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int unsigned k = 0; k < unsigned'(ReadLatency - 1); k++) begin
                    stage_v[k] <= 1'b0;
                end
            end else begin
                stage_v[0] <= do_read;
                for (int unsigned k = 1; k < unsigned'(ReadLatency - 1); k++) begin
                    stage_v[k] <= stage_v[k-1];
                end
            end
        end

        // Data stages shift every cycle; only the valid bits matter.
        always_ff @(posedge clk) begin
            stage_d[0] <= rd_data;
            for (int unsigned k = 1; k < unsigned'(ReadLatency - 1); k++) begin
                stage_d[k] <= stage_d[k-1];
            end
        end

        assign tail_v = stage_v[ReadLatency-2];
        assign tail_d = stage_d[ReadLatency-2];
    end

    // Output register: dout holds between completions, oobErr is sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout   <= '0;
            dValid <= 1'b0;
            oobErr <= 1'b0;
        end else begin
            dValid <= tail_v;
            if (tail_v) begin
                dout <= tail_d;
            end
            if (access && !in_range) begin
                oobErr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_openram_sram_model.sv
// Bench for openram_sram_model: three instances (ReadLatency 1, 2, 3) share
// one stimulus stream; a scoreboard per instance holds expected read data
// and the cycle each completion is due.
module tb_openram_sram_model;

    localparam int NI = 3;

    typedef struct packed {
        int unsigned due;
        logic [31:0] data;
    } exp_t;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic            csb   = 1'b1;
    logic            web   = 1'b1;
    logic [31:0]     addr  = '0;
    logic [31:0]     din   = '0;
`ifdef OPENRAM_WMASK_EN
    logic [3:0]      wmask = 4'hF;
`endif
    logic [31:0]     dout_a [NI];
    logic [NI-1:0]   dv;
    logic [NI-1:0]   oob;

    int unsigned     cyc   = 0;
    int              total = 0;
    int              bad   = 0;
    exp_t            q [NI][$];
    exp_t            mon_e;
    logic [31:0]     mdl [int];
    logic            oob_m = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    openram_sram_model #(.DataWidth(32), .AddrWidth(32), .Depth(1024), .ReadLatency(1)) u_l1 (
        .clk(clk), .reset(reset), .csb(csb), .web(web), .addr(addr), .din(din),
`ifdef OPENRAM_WMASK_EN
        .wmask(wmask),
`endif
        .dout(dout_a[0]), .dValid(dv[0]), .oobErr(oob[0])
    );

    openram_sram_model #(.DataWidth(32), .AddrWidth(32), .Depth(1024), .ReadLatency(2)) u_l2 (
        .clk(clk), .reset(reset), .csb(csb), .web(web), .addr(addr), .din(din),
`ifdef OPENRAM_WMASK_EN
        .wmask(wmask),
`endif
        .dout(dout_a[1]), .dValid(dv[1]), .oobErr(oob[1])
    );

    openram_sram_model #(.DataWidth(32), .AddrWidth(32), .Depth(1024), .ReadLatency(3)) u_l3 (
        .clk(clk), .reset(reset), .csb(csb), .web(web), .addr(addr), .din(din),
`ifdef OPENRAM_WMASK_EN
        .wmask(wmask),
`endif
        .dout(dout_a[2]), .dValid(dv[2]), .oobErr(oob[2])
    );

    // Scoreboard monitor: every dValid must match the head entry and its due cycle.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (dv[i] === 1'b1) begin
                total++;
                if (q[i].size() == 0 || q[i][0].due != cyc) begin
                    bad++;
                    $display("FAIL unexpected_dvalid lat=%0d cyc=%0d got dout=%h, required no completion",
                             i + 1, cyc, dout_a[i]);
                    if (q[i].size() != 0 && q[i][0].due < cyc) void'(q[i].pop_front());
                end else begin
                    mon_e = q[i].pop_front();
                    if (dout_a[i] !== mon_e.data) begin
                        bad++;
                        $display("FAIL read_data lat=%0d cyc=%0d got=%h required=%h",
                                 i + 1, cyc, dout_a[i], mon_e.data);
                    end
                end
            end else if (q[i].size() != 0 && q[i][0].due <= cyc) begin
                total++;
                bad++;
                $display("FAIL missing_dvalid lat=%0d cyc=%0d got dValid=%b, required 1 with dout=%h",
                         i + 1, cyc, dv[i], q[i][0].data);
                void'(q[i].pop_front());
            end
        end
    end

    // One request cycle; updates the model and pushes expected reads.
    task automatic step(input logic c, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m);
        logic [31:0] e;
        logic [3:0]  m_eff;
`ifdef OPENRAM_WMASK_EN
        m_eff = m;
        wmask = m;
`else
        m_eff = m | 4'hF;
`endif
        csb  = c;
        web  = w;
        addr = a;
        din  = d;
        if (!c) begin
            if (a >= 32'd1024) oob_m = 1'b1;
            if (!w) begin
                if (a < 32'd1024) begin
                    e = mdl.exists(int'(a)) ? mdl[int'(a)] : '0;
                    for (int b = 0; b < 4; b++) begin
                        if (m_eff[b]) e[8*b +: 8] = d[8*b +: 8];
                    end
                    mdl[int'(a)] = e;
                end
            end else begin
                e = (a < 32'd1024) ? mdl[int'(a)] : '0;
                for (int i = 0; i < NI; i++) begin
                    q[i].push_back('{due: cyc + unsigned'(i + 1), data: e});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b1, 32'd0, 32'd0, 4'hF);
    endtask

    // Reads completing at or after the reset edge are dropped by the DUT.
    task automatic apply_reset(input int n);
        reset = 1'b1;
        csb   = 1'b1;
        web   = 1'b1;
        for (int i = 0; i < NI; i++) begin
            while (q[i].size() != 0 && q[i][$].due >= cyc + 1) void'(q[i].pop_back());
        end
        oob_m = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        int left;
        for (int k = 0; k < 20; k++) begin
            left = 0;
            for (int i = 0; i < NI; i++) left += q[i].size();
            if (left == 0) break;
            idle(1);
        end
        left = 0;
        for (int i = 0; i < NI; i++) left += q[i].size();
        total++;
        if (left != 0) begin
            bad++;
            $display("FAIL drain_timeout got pending=%0d required=0", left);
            for (int i = 0; i < NI; i++) q[i].delete();
        end
    endtask

    task automatic test_reset();
        apply_reset(2);
        for (int k = 0; k < 11; k++) begin
            for (int i = 0; i < NI; i++) begin
                total++;
                if (dout_a[i] !== 32'd0 || dv[i] !== 1'b0 || oob[i] !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_idle lat=%0d k=%0d got dout=%h dValid=%b oobErr=%b required 0/0/0",
                             i + 1, k, dout_a[i], dv[i], oob[i]);
                end
            end
            if (k < 10) idle(1);
        end
    endtask

    task automatic test_lat1_basic();
        step(1'b0, 1'b0, 32'd5, 32'hDEADBEEF, 4'hF);
        step(1'b0, 1'b1, 32'd5, 32'd0, 4'hF);
        csb = 1'b1;
        total++;
        if (dv[0] !== 1'b1 || dout_a[0] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL lat1_next_cycle got dValid=%b dout=%h required 1/deadbeef", dv[0], dout_a[0]);
        end
        drain();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NI; i++) begin
                total++;
                if (dout_a[i] !== 32'hDEADBEEF || dv[i] !== 1'b0) begin
                    bad++;
                    $display("FAIL dout_hold lat=%0d got dout=%h dValid=%b required deadbeef/0",
                             i + 1, dout_a[i], dv[i]);
                end
            end
            idle(1);
        end
    endtask

    task automatic test_stream();
        for (int a = 0; a < 4; a++) step(1'b0, 1'b0, 32'(a), 32'h10 + 32'(a), 4'hF);
        for (int a = 0; a < 4; a++) step(1'b0, 1'b1, 32'(a), 32'd0, 4'hF);
        drain();
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b0, 32'd9, 32'h0BADF00D, 4'hF);
        step(1'b0, 1'b1, 32'd9, 32'd0, 4'hF);
        step(1'b0, 1'b0, 32'd9, 32'hCAFEF00D, 4'hF);
        step(1'b0, 1'b1, 32'd9, 32'd0, 4'hF);
        step(1'b0, 1'b1, 32'd5, 32'd0, 4'hF);
        drain();
    endtask

    task automatic test_oob();
        total++;
        if (oob !== 3'b000) begin
            bad++;
            $display("FAIL oob_before got=%b required=000", oob);
        end
        step(1'b0, 1'b0, 32'd1024, 32'hAAAA5555, 4'hF);
        total++;
        if (oob !== {NI{oob_m}} || oob_m !== 1'b1) begin
            bad++;
            $display("FAIL oob_set got=%b required=111", oob);
        end
        step(1'b0, 1'b1, 32'd1024, 32'd0, 4'hF);
        step(1'b0, 1'b1, 32'd0, 32'd0, 4'hF);
        step(1'b0, 1'b1, 32'hFFFFFFFF, 32'd0, 4'hF);
        drain();
        total++;
        if (oob !== 3'b111) begin
            bad++;
            $display("FAIL oob_sticky got=%b required=111", oob);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b0, 32'd7, 32'h7777AAAA, 4'hF);
        step(1'b0, 1'b1, 32'd7, 32'd0, 4'hF);
        apply_reset(1);
        for (int i = 0; i < NI; i++) begin
            total++;
            if (dout_a[i] !== 32'd0 || dv[i] !== 1'b0 || oob[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid lat=%0d got dout=%h dValid=%b oobErr=%b required 0/0/0",
                         i + 1, dout_a[i], dv[i], oob[i]);
            end
        end
        idle(4);
        step(1'b0, 1'b1, 32'd7, 32'd0, 4'hF);
        drain();
        total++;
        if (dout_a[1] !== 32'h7777AAAA) begin
            bad++;
            $display("FAIL reset_mid_retained got=%h required=7777aaaa", dout_a[1]);
        end
    endtask

`ifdef OPENRAM_WMASK_EN
    task automatic test_wmask();
        step(1'b0, 1'b0, 32'd2, 32'h11223344, 4'hF);
        step(1'b0, 1'b0, 32'd2, 32'hFFFFFFFF, 4'b0101);
        step(1'b0, 1'b0, 32'd2, 32'h00000000, 4'b0000);
        step(1'b0, 1'b1, 32'd2, 32'd0, 4'hF);
        drain();
        total++;
        if (dout_a[2] !== 32'h11FF33FF) begin
            bad++;
            $display("FAIL wmask_merge got=%h required=11ff33ff", dout_a[2]);
        end
    endtask
`endif

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_lat1_basic();
        test_stream();
        test_back_to_back();
`ifdef OPENRAM_WMASK_EN
        test_wmask();
`endif
        test_oob();
        test_reset_mid();
        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no finish, required finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/openram_sram_model.md
Name: openram_sram_model

Overview:
- Behavioural single-port SRAM that responds on the OpenRAM macro side of the memory controller.
- It samples chip-select, write-enable, address and data on each rising edge.
- It returns read data after a configurable pipeline latency.
- It is the device-under-controller for controller benches and the stand-in for the hard macro in simulation.

Parameters:
- DataWidth, 32, word width in bits; must be a multiple of 8.
- AddrWidth, 32, address port width; the address is a word index.
- Depth, 1024, number of stored words; indices Depth and above are out of range.
- ReadLatency, 1, cycles from the sampled read to valid dout; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- reset  in  1  synchronous, active-high reset.
- csb  in  1  chip select, active low.
- web  in  1  write enable, active low; only meaningful while csb=0.
- addr  in  AddrWidth  word index.
- din  in  DataWidth  write data.
- dout  out  DataWidth  read data; holds its last value between reads.
- dValid  out  1  one-cycle pulse in the cycle dout presents new read data.
- oobErr  out  1  sticky flag: an out-of-range access has occurred.

Behaviour:
- Reset (reset=1 at a rising edge):
  - dout=0, dValid=0, oobErr=0.
  - All read-pipeline stages are invalidated; in-flight reads are dropped and never produce dValid.
  - Array contents are not reset.
- Idle (csb=1): the array is unchanged, no pipeline entry is issued, and dout holds.
- Write (csb=0, web=0, addr<Depth): mem[addr] is updated at that edge. No read is issued. dout is unchanged by writes.
- Read (csb=0, web=1, addr<Depth):
  - mem[addr] is captured at the sampling edge into stage 1.
  - It advances one stage per edge.
  - dout and dValid update at edge ReadLatency after sampling. With ReadLatency=1, data is visible in the cycle after the request.
- Back-to-back reads are accepted every cycle; the pipeline is fully pipelined with no stalls. dValid stays high across consecutive completions.
- Write then read, same address, next cycle: the read returns the newly written data (array write precedes the later sample).
- A read issued while earlier reads are in flight does not disturb them; completions stay in issue order.
- Out of range (csb=0, addr>=Depth):
  - A write is discarded.
  - A read is still pipelined and completes with dout=0 and dValid=1.
  - oobErr sets at the sampling edge and is cleared only by reset.
- An access requested in the same cycle that reset=1 is ignored.
- Elaboration must fail if ReadLatency is outside 1..4, DataWidth%8!=0, or Depth>2**AddrWidth.

Optional Feature:
- Macro: OPENRAM_WMASK_EN.
- When defined:
  - The block adds input port wmask, width DataWidth/8.
  - On a write, byte i of mem[addr] is updated only where wmask[i]=1; other bytes keep their old value.
  - A write with wmask=0 leaves the word unchanged but still checks the address range for oobErr.
- When undefined: the port is absent and every write updates the full word.

Test Plan:
- Reset then idle: after reset, dout=0, dValid=0, oobErr=0, and they stay so for 10 cycles with csb=1.
- ReadLatency=1: write addr 5 with 0xDEADBEEF, then read addr 5 the next cycle. One cycle later, dout=0xDEADBEEF with dValid=1 for exactly one cycle; dout then holds after csb returns to 1.
- ReadLatency=3, streaming: write addrs 0..3 with 0x10..0x13, then read 0..3 on consecutive cycles. dValid is high for 4 consecutive cycles starting 3 cycles after the first read, with dout 0x10,0x11,0x12,0x13 in order.
- Out of range, Depth=1024: write 0xAAAA5555 to addr 1024, then read addr 1024. The read returns dout=0 with dValid=1. oobErr is set from the write's sampling edge onward. mem[0] is unchanged.
- Reset mid-operation, ReadLatency=2: issue a read of addr 7, then assert reset on the next edge. No dValid occurs. dout=0 after reset. A later read of addr 7 returns its pre-reset contents.
- OPENRAM_WMASK_EN: write 0x11223344 to addr 2, then write 0xFFFFFFFF to addr 2 with wmask=4'b0101, then read addr 2. dout=0x11FF33FF.
